spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 DWIDTH, 32, data field width in bits; legal values 16..64.
REQ-002 AWIDTH, 8, address field width in bits.
REQ-003 NREGS, 16, number of internal registers; a register is selected by ADDR[log2(NREGS)-1:0].
REQ-004 clk  input  1  global clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sclk  input  1  SPI clock from the master, asynchronous to clk, mode 0.
REQ-007 cs_n  input  1  slave select, active-low.
REQ-008 mosi  input  1  master-out serial data.
REQ-009 miso  output  1  slave-out serial data.
REQ-010 miso_oe  output  1  miso output enable.
REQ-011 frame_done  output  1  one-clk pulse when a complete frame is accepted.
REQ-012 frame_wr  output  1  WR_EN of the last complete frame.
REQ-013 frame_addr  output  AWIDTH  ADDR of the last complete frame.

Function
REQ-014 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer; sclk edges SHALL be detected on synchronized values; sclk period SHALL be ≥8 clk periods.
REQ-015 Frame, MSB first: WR_EN(1), SIZE(2), ADDR(AWIDTH), DATA(DWIDTH); total 3+AWIDTH+DWIDTH bits (43 at defaults).
REQ-016 mosi SHALL be sampled on synchronized sclk rising edges; miso SHALL change only on synchronized sclk falling edges.
REQ-017 FSM states: IDLE, HDR, DATA, HOLD.
REQ-018 IDLE->HDR on synchronized cs_n falling; bit counter cleared.
REQ-019 HDR->DATA after the (3+AWIDTH)th rising edge; WR_EN, SIZE and ADDR latched.
REQ-020 For a read in DATA, the slave SHALL load the read word into the shift register on the first falling edge after the header and drive its MSB on miso; remaining bits SHALL follow MSB first, one per falling edge.
REQ-021 For a write in DATA, bits are shifted in; after the last rising edge, the register write SHALL occur within 2 clk cycles.
REQ-022 DATA->HOLD after the last data bit; frame_done SHALL pulse one cycle; frame_wr and frame_addr SHALL update in the same cycle.
REQ-023 In HOLD, extra sclk edges SHALL be ignored; miso=0; HOLD->IDLE on synchronized cs_n rising.
REQ-024 SIZE 00 writes bits[7:0] only; 01 writes [15:0] only; 10 writes all DWIDTH bits; unwritten bits of the register SHALL be preserved.
REQ-025 Read data SHALL be the register value masked to the SIZE width and zero-extended.
REQ-026 SIZE 11 (reserved) SHALL perform no write, SHALL return all-zero read data, and SHALL still pulse frame_done.
REQ-027 Upper ADDR bits above log2(NREGS) SHALL be ignored (address aliasing).
REQ-028 cs_n rising in HDR or DATA SHALL abort the frame: no register write, no frame_done, return to IDLE.
REQ-029 miso_oe SHALL equal NOT synchronized cs_n; miso SHALL be 0 outside the read DATA phase.
REQ-030 A cs_n falling edge while in HOLD without an intervening rising edge SHALL be impossible; a new frame SHALL start only from IDLE.

Reset
REQ-031 rst_n low SHALL force IDLE, clear counters, shift registers and synchronizers, and clear all registers to 0.
REQ-032 Reset outputs: miso=0, miso_oe=0, frame_done=0, frame_wr=0, frame_addr=0.
REQ-033 Reset asserted mid-frame SHALL discard the frame; the next frame SHALL require a fresh cs_n falling edge after rst_n deasserts.

Configuration
REQ-034 Macro SPI_SLV_ABORT_CNT_EN: when defined, adds output abort_cnt (8 bits), which increments on each REQ-028 abort, saturates at 255, and is reset to 0.
REQ-035 Without SPI_SLV_ABORT_CNT_EN, the abort_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-036 Write frame 1,10,0x03,0xDEADBEEF, then read frame 0,10,0x03 -> miso returns 0xDEADBEEF; frame_done pulses twice; frame_addr=0x03.
REQ-037 Write 1,00,0x05,0x11223344 to a register holding 0xAAAAAAAA -> register becomes 0xAAAAAA44; read with SIZE 01 returns 0x0000AA44.
REQ-038 Raise cs_n after 20 bits of a write to 0x07 -> register 7 unchanged, no frame_done, abort_cnt=1 when SPI_SLV_ABORT_CNT_EN is defined.
REQ-039 Write to ADDR 0x13 with NREGS=16, then read 0x03 -> value aliased to register 3; SIZE 11 read returns 0.
REQ-040 Assert rst_n low at bit 30 of a write, release it, then run a full read frame -> read returns 0, outputs at reset values during reset.
REQ-041 Send 50 sclk pulses in one frame -> exactly one frame_done; bits 44-50 ignored.

Source files
------------

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave : SPI mode-0 slave in front of a small register file.
//
// Each frame on the serial side is, MSB first:
//   WR_EN(1) SIZE(2) ADDR(AWIDTH) DATA(DWIDTH)
// A write frame merges DATA into the selected register under a SIZE mask.
// A read frame returns the masked register on miso during the DATA phase.
// All logic runs on clk. sclk, cs_n and mosi are double-flop synchronised.
//
// Ports
//   clk, rst_n    : system clock, asynchronous active-low reset
//   sclk          : SPI clock from the master, mode 0, period >= 8 clk
//   cs_n          : slave select, active low
//   mosi          : master-out serial data
//   miso          : slave-out serial data, 0 outside the read DATA phase
//   miso_oe       : miso output enable, NOT of synchronised cs_n
//   frame_done    : one-clk pulse when a complete frame has been accepted
//   frame_wr      : WR_EN of the last complete frame
//   frame_addr    : ADDR of the last complete frame
//   abort_cnt     : saturating count of frames aborted by cs_n rising
//                   (present only when SPI_SLV_ABORT_CNT_EN is defined)
//
// Optional feature macro: SPI_SLV_ABORT_CNT_EN
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              frame_done,
  output logic              frame_wr,
  output logic [AWIDTH-1:0] frame_addr
`ifdef SPI_SLV_ABORT_CNT_EN
  ,
  output logic [7:0]        abort_cnt
`endif
);

  localparam int unsigned IDXW  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned NHDR  = 3 + AWIDTH;
  localparam int unsigned NBITS = NHDR + DWIDTH;
  localparam int unsigned CNTW  = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  // SIZE field to byte-lane mask; the reserved code selects nothing.
  function automatic logic [DWIDTH-1:0] size_mask(input logic [1:0] sz);
    logic [DWIDTH-1:0] m;
    case (sz)
      2'b00:   m = DWIDTH'(8'hFF);
      2'b01:   m = DWIDTH'(16'hFFFF);
      2'b10:   m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] sclk_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] mosi_sync_q;
  logic [1:0] cs_vld_q;
  logic       sclk_prev_q;
  logic       cs_prev_q;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic cs_vld;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  // cs_n synchroniser resets to the deselected level so miso_oe is low in reset.
  // cs_vld_q marks when real pin data has reached the synchroniser output; until
  // then no cs_n edge is reported. cs_prev_q resets to "selected", so a cs_n
  // held low across reset release never looks like a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      cs_vld_q    <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      cs_vld_q    <= {cs_vld_q[0], 1'b1};
      sclk_prev_q <= sclk_sync_q[1];
      if (cs_vld_q[1]) begin
        cs_prev_q <= cs_sync_q[1];
      end
    end
  end

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign cs_vld    = cs_vld_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = cs_vld & cs_prev_q & ~cs_s;
  assign cs_rise   = cs_vld & ~cs_prev_q & cs_s;

  // ---------------------------------------------------------------------------
  // Frame state and datapath registers
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

  logic [CNTW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NHDR-1:0]   hdr_q, hdr_d;
  logic [DWIDTH-1:0] sh_q, sh_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              load_pend_q, load_pend_d;
  logic              miso_q, miso_d;
  logic              done_q, done_d;
  logic              fwr_q, fwr_d;
  logic [AWIDTH-1:0] faddr_q, faddr_d;
  logic [DWIDTH-1:0] regs_q [NREGS];
`ifdef SPI_SLV_ABORT_CNT_EN
  logic [7:0]        abort_cnt_q, abort_cnt_d;
`endif

  logic              last_hdr;
  logic              last_bit;
  logic              abort;
  logic [IDXW-1:0]   ridx;
  logic [DWIDTH-1:0] mask_c;
  logic [DWIDTH-1:0] rdata_c;
  logic [DWIDTH-1:0] wdata_c;
  logic              reg_we_c;

  assign last_hdr = (bit_cnt_q == CNTW'(NHDR - 1));
  assign last_bit = (bit_cnt_q == CNTW'(NBITS - 1));
  assign abort    = ((state_q == S_HDR) || (state_q == S_DATA)) && cs_rise;
  assign ridx     = addr_q[IDXW-1:0];
  assign mask_c   = size_mask(size_q);
  assign rdata_c  = regs_q[ridx] & mask_c;
  // Final write word includes the bit sampled on the last rising edge.
  assign wdata_c  = {sh_q[DWIDTH-2:0], mosi_s};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; cs_n rising always wins over a coincident sclk edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cs_fall) state_d = S_HDR;
      S_HDR: begin
        if (cs_rise)                    state_d = S_IDLE;
        else if (sclk_rise && last_hdr) state_d = S_DATA;
      end
      S_DATA: begin
        if (cs_rise)                    state_d = S_IDLE;
        else if (sclk_rise && last_bit) state_d = S_HOLD;
      end
      S_HOLD: if (cs_rise) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-values
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    hdr_d       = hdr_q;
    sh_d        = sh_q;
    wr_d        = wr_q;
    size_d      = size_q;
    addr_d      = addr_q;
    load_pend_d = load_pend_q;
    miso_d      = miso_q;
    done_d      = 1'b0;
    fwr_d       = fwr_q;
    faddr_d     = faddr_q;
    reg_we_c    = 1'b0;
`ifdef SPI_SLV_ABORT_CNT_EN
    abort_cnt_d = abort_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          bit_cnt_d   = '0;
          load_pend_d = 1'b0;
        end
      end

      S_HDR: begin
        if (cs_rise) begin
          miso_d = 1'b0;
        end else if (sclk_rise) begin
          hdr_d     = {hdr_q[NHDR-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CNTW'(1);
          if (last_hdr) begin
            wr_d        = hdr_d[NHDR-1];
            size_d      = hdr_d[NHDR-2 -: 2];
            addr_d      = hdr_d[AWIDTH-1:0];
            sh_d        = '0;
            load_pend_d = 1'b1;
          end
        end
      end

      S_DATA: begin
        if (cs_rise) begin
          miso_d = 1'b0;
        end else if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + CNTW'(1);
          if (wr_q) begin
            sh_d = wdata_c;
          end
          if (last_bit) begin
            done_d   = 1'b1;
            fwr_d    = wr_q;
            faddr_d  = addr_q;
            miso_d   = 1'b0;
            reg_we_c = wr_q && (size_q != 2'b11);
          end
        end else if (sclk_fall && !wr_q) begin
          // First falling edge fetches the read word; later ones shift it out.
          if (load_pend_q) begin
            sh_d        = rdata_c;
            miso_d      = rdata_c[DWIDTH-1];
            load_pend_d = 1'b0;
          end else begin
            sh_d   = {sh_q[DWIDTH-2:0], 1'b0};
            miso_d = sh_q[DWIDTH-2];
          end
        end
      end

      S_HOLD: begin
        miso_d = 1'b0;
      end

      default: begin
        miso_d = 1'b0;
      end
    endcase

`ifdef SPI_SLV_ABORT_CNT_EN
    if (abort && (abort_cnt_q != 8'hFF)) begin
      abort_cnt_d = abort_cnt_q + 8'd1;
    end
`endif
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      hdr_q       <= '0;
      sh_q        <= '0;
      wr_q        <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      load_pend_q <= 1'b0;
      miso_q      <= 1'b0;
      done_q      <= 1'b0;
      fwr_q       <= 1'b0;
      faddr_q     <= '0;
`ifdef SPI_SLV_ABORT_CNT_EN
      abort_cnt_q <= 8'd0;
`endif
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      hdr_q       <= hdr_d;
      sh_q        <= sh_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      load_pend_q <= load_pend_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      fwr_q       <= fwr_d;
      faddr_q     <= faddr_d;
`ifdef SPI_SLV_ABORT_CNT_EN
      abort_cnt_q <= abort_cnt_d;
`endif
    end
  end

  // Register file; a write merges only the SIZE-selected lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we_c) begin
      regs_q[ridx] <= (regs_q[ridx] & ~mask_c) | (wdata_c & mask_c);
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = ~cs_s;
  assign frame_done = done_q;
  assign frame_wr   = fwr_q;
  assign frame_addr = faddr_q;
`ifdef SPI_SLV_ABORT_CNT_EN
  assign abort_cnt  = abort_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave : randomized SPI master driving spi_slave, with a register-file
// reference model. Expected frame results are queued when a frame is issued
// and checked by a separate monitor on every frame_done pulse.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int NH   = 11;
  localparam int NB   = 43;
  localparam int HALF = 60;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       frame_done;
  logic       frame_wr;
  logic [7:0] frame_addr;
`ifdef SPI_SLV_ABORT_CNT_EN
  logic [7:0] abort_cnt;
`endif

  spi_slave dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .frame_done (frame_done),
    .frame_wr   (frame_wr),
    .frame_addr (frame_addr)
`ifdef SPI_SLV_ABORT_CNT_EN
    ,
    .abort_cnt  (abort_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] cap_q[$];
  logic [31:0] mregs[16];

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  int n_complete  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: SIZE selects a width in bits, addresses alias modulo 16.
  function automatic int size_bits(input logic [1:0] sz);
    return (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : (sz == 2'd2) ? 32 : 0;
  endfunction

  function automatic logic [31:0] width_mask(input int w);
    logic [63:0] t;
    t = (64'd1 << w) - 64'd1;
    return t[31:0];
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [1:0] sz,
                                      input logic [31:0] d);
    logic [31:0] m;
    int idx;
    m   = width_mask(size_bits(sz));
    idx = int'(a) % 16;
    mregs[idx] = (mregs[idx] & ~m) | (d & m);
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a, input logic [1:0] sz);
    return mregs[int'(a) % 16] & width_mask(size_bits(sz));
  endfunction

  // One SPI frame. npulse sclk pulses; abort_at / rst_at (>=0) cut the frame
  // short by raising cs_n or pulsing rst_n just before that bit.
  task automatic spi_frame(input logic wr, input logic [1:0] sz, input logic [7:0] ad,
                           input logic [31:0] dat, input int npulse,
                           input int abort_at, input int rst_at);
    logic [NB-1:0] fr;
    logic [31:0]   cap;
    exp_t          e;
    bit            complete;
    fr       = {wr, sz, ad, dat};
    cap      = '0;
    complete = (abort_at < 0) && (rst_at < 0) && (npulse >= NB);
    if (complete) begin
      e.wr   = wr;
      e.addr = ad;
      e.rd   = wr ? 32'd0 : model_read(ad, sz);
      if (wr) model_write(ad, sz, dat);
      exp_q.push_back(e);
      n_complete++;
    end
    @(negedge clk);
    cs_n = 1'b0;
    #(HALF);
    for (int i = 0; i < npulse; i++) begin
      if (i == abort_at) break;
      if (i == rst_at) begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst miso", 64'(miso), 64'd0);
        chk("rst miso_oe", 64'(miso_oe), 64'd0);
        chk("rst frame_done", 64'(frame_done), 64'd0);
        chk("rst frame_wr", 64'(frame_wr), 64'd0);
        chk("rst frame_addr", 64'(frame_addr), 64'd0);
`ifdef SPI_SLV_ABORT_CNT_EN
        chk("rst abort_cnt", 64'(abort_cnt), 64'd0);
`endif
        foreach (mregs[k]) mregs[k] = '0;
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        break;
      end
      mosi = (i < NB) ? fr[NB-1-i] : 1'b1;
      #(HALF);
      sclk = 1'b1;
      if (i >= NH && i < NB) cap = {cap[30:0], miso};
      if (i == 5) chk("miso_oe in frame", 64'(miso_oe), 64'd1);
      if (i >= NB + 2) chk("miso in HOLD", 64'(miso), 64'd0);
      if (complete && i == NB - 1) cap_q.push_back(cap);
      #(HALF);
      sclk = 1'b0;
    end
    #(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("miso_oe idle", 64'(miso_oe), 64'd0);
  endtask

  // Monitor: every frame_done pops and checks one expected frame.
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected frame_done", 64'd1, 64'd0);
      end else begin
        exp_t        e;
        logic [31:0] c;
        e = exp_q.pop_front();
        chk("frame_wr", 64'(frame_wr), 64'(e.wr));
        chk("frame_addr", 64'(frame_addr), 64'(e.addr));
        if (!e.wr) begin
          if (cap_q.size() == 0) begin
            chk("read capture missing", 64'd1, 64'd0);
          end else begin
            c = cap_q.pop_front();
            chk("read data", 64'(c), 64'(e.rd));
          end
        end else if (cap_q.size() != 0) begin
          c = cap_q.pop_front();
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    int d0;
    foreach (mregs[k]) mregs[k] = '0;
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset miso", 64'(miso), 64'd0);
    chk("reset miso_oe", 64'(miso_oe), 64'd0);
    chk("reset frame_done", 64'(frame_done), 64'd0);
    chk("reset frame_wr", 64'(frame_wr), 64'd0);
    chk("reset frame_addr", 64'(frame_addr), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Full-width write then read back.
    spi_frame(1'b1, 2'b10, 8'h03, 32'hDEADBEEF, NB, -1, -1);
    spi_frame(1'b0, 2'b10, 8'h03, 32'h0, NB, -1, -1);
    #1;
    chk("frame_addr after read", 64'(frame_addr), 64'h03);
    chk("two frame_done", 64'(done_seen), 64'd2);

    // Byte write preserves upper bits; halfword read masks.
    spi_frame(1'b1, 2'b10, 8'h05, 32'hAAAAAAAA, NB, -1, -1);
    spi_frame(1'b1, 2'b00, 8'h05, 32'h11223344, NB, -1, -1);
    spi_frame(1'b0, 2'b01, 8'h05, 32'h0, NB, -1, -1);
    spi_frame(1'b0, 2'b10, 8'h05, 32'h0, NB, -1, -1);

    // Abort after 20 bits leaves the register untouched.
    spi_frame(1'b1, 2'b10, 8'h07, 32'hCAFEF00D, NB, -1, -1);
    d0 = done_seen;
    spi_frame(1'b1, 2'b10, 8'h07, 32'h12345678, NB, 20, -1);
    repeat (10) @(posedge clk);
    #1;
    chk("no frame_done on abort", 64'(done_seen), 64'(d0));
`ifdef SPI_SLV_ABORT_CNT_EN
    chk("abort_cnt", 64'(abort_cnt), 64'd1);
`endif
    spi_frame(1'b0, 2'b10, 8'h07, 32'h0, NB, -1, -1);

    // Address aliasing and the reserved SIZE code.
    spi_frame(1'b1, 2'b10, 8'h13, 32'h55AA1234, NB, -1, -1);
    spi_frame(1'b0, 2'b10, 8'h03, 32'h0, NB, -1, -1);
    spi_frame(1'b0, 2'b11, 8'h03, 32'h0, NB, -1, -1);
    spi_frame(1'b1, 2'b11, 8'h03, 32'hFFFFFFFF, NB, -1, -1);
    spi_frame(1'b0, 2'b10, 8'h03, 32'h0, NB, -1, -1);

    // Over-long frame: extra pulses ignored, one frame_done.
    d0 = done_seen;
    spi_frame(1'b1, 2'b10, 8'h09, 32'h0F0F0F0F, 50, -1, -1);
    #1;
    chk("one frame_done for 50 pulses", 64'(done_seen), 64'(d0 + 1));
    spi_frame(1'b0, 2'b10, 8'h09, 32'h0, 50, -1, -1);

    // Randomized traffic.
    for (int k = 0; k < 25; k++) begin
      logic        wr;
      logic [1:0]  sz;
      logic [7:0]  ad;
      logic [31:0] d;
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ad = 8'($urandom);
      d  = $urandom;
      spi_frame(wr, sz, ad, d, NB, -1, -1);
    end

    // Reset mid-write wipes the register file.
    spi_frame(1'b1, 2'b10, 8'h03, 32'h87654321, NB, -1, 30);
    repeat (10) @(posedge clk);
    spi_frame(1'b0, 2'b10, 8'h03, 32'h0, NB, -1, -1);

    repeat (20) @(posedge clk);
    #1;
    chk("total frame_done", 64'(done_seen), 64'(n_complete));
    chk("pending expectations", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
